// File: rtl/cpu_types_pkg.sv
// Shared types for the dcache snoop responder: FSM states, snoop address layout, cache geometry.
package cpu_types_pkg;

  localparam int WAYS      = 2;
  localparam int BLK_WORDS = 2;
  localparam int WORD_W    = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    SEND0,
    SEND1,
    UPDATE,
    DONE
  } snoop_state_t;

  // Field layout at the default geometry (8 sets, 26-bit tag).
  typedef struct packed {
    logic [25:0] tag;
    logic [2:0]  idx;
    logic        blkoff;
    logic [1:0]  bytoff;
  } dcache_snp_addr_t;

endpackage

// File: rtl/snoop_tag_match.sv
// Combinational 2-way tag compare for the snoop lookup; way0 wins a double match.
module snoop_tag_match
  import cpu_types_pkg::*;
#(
  parameter int TAG_W = 26
) (
  input  logic [WAYS*TAG_W-1:0] way_tag,
  input  logic [WAYS-1:0]       way_valid,
  input  logic [TAG_W-1:0]      tag,
  output logic                  hit,
  output logic                  hit_way
);

  logic [WAYS-1:0] match;

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_match
      assign match[gi] = way_valid[gi] && (way_tag[gi*TAG_W +: TAG_W] == tag);
    end
  endgenerate

  assign hit     = |match;
  assign hit_way = ~match[0] & match[1];

endmodule

// File: rtl/snoop_responder.sv
// Snoop responder for one dcache: tag lookup, two-word write-back of M lines, S/I downgrade.
// Optional LL/SC link clearing on invalidating snoops is enabled by defining LLSC_SNOOP_EN.
module snoop_responder
  import cpu_types_pkg::*;
#(
  parameter int SETS  = 8,
  parameter int IDX_W = 3
) (
  input  logic                              CLK,
  input  logic                              nRST,
  input  logic                              ccwait,
  input  logic                              ccinv,
  input  logic [31:0]                       ccsnoopaddr,
  input  logic                              dwait,
  output logic                              cctrans,
  output logic                              ccwrite,
  output logic [31:0]                       dstore,
  output logic [31:0]                       daddr,
  output logic [IDX_W-1:0]                  snp_idx,
  input  logic [WAYS-1:0]                   way_valid,
  input  logic [WAYS-1:0]                   way_dirty,
  input  logic [WAYS*(29-IDX_W)-1:0]        way_tag,
  input  logic [WAYS*BLK_WORDS*WORD_W-1:0]  way_data,
  output logic                              snp_wen,
  output logic                              snp_way,
  output logic                              snp_valid_n,
  output logic                              snp_dirty_n,
  output logic                              snoop_busy,
  output logic                              link_clear,
  input  logic [31:0]                       link_addr
);

  localparam int TAG_W = 29 - IDX_W;

  snoop_state_t state_reg, state_next;
  logic [28:0]  addr_reg;   // snooped block address, bits [31:3]
  logic         inv_reg;
  logic         way_reg;

  logic             hit, hit_way, hit_dirty;
  logic             word_sel;
  logic             sending;
  logic [WORD_W-1:0] blk_words [WAYS*BLK_WORDS];

  snoop_tag_match #(.TAG_W(TAG_W)) u_tag_match (
    .way_tag   (way_tag),
    .way_valid (way_valid),
    .tag       (addr_reg[28:IDX_W]),
    .hit       (hit),
    .hit_way   (hit_way)
  );

  assign hit_dirty = way_dirty[hit_way];

  generate
    for (genvar gi = 0; gi < WAYS*BLK_WORDS; gi++) begin : g_words
      assign blk_words[gi] = way_data[gi*WORD_W +: WORD_W];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      inv_reg   <= 1'b0;
      way_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && ccwait) begin
        addr_reg <= ccsnoopaddr[31:3];
        inv_reg  <= ccinv;
      end
      if (state_reg == LOOKUP) begin
        way_reg <= hit_way;
      end
    end
  end

  // Losing ccwait before UPDATE abandons the snoop with the line untouched.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (ccwait) state_next = LOOKUP;
      LOOKUP: begin
        if (!ccwait)                state_next = IDLE;
        else if (hit && hit_dirty)  state_next = SEND0;
        else if (hit)               state_next = UPDATE;
        else                        state_next = DONE;
      end
      SEND0: begin
        if (!ccwait)     state_next = IDLE;
        else if (!dwait) state_next = SEND1;
      end
      SEND1: begin
        if (!ccwait)     state_next = IDLE;
        else if (!dwait) state_next = UPDATE;
      end
      UPDATE:  state_next = DONE;
      DONE:    if (!ccwait) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign sending  = (state_reg == SEND0) || (state_reg == SEND1);
  assign word_sel = (state_reg == SEND1);

  assign snoop_busy  = (state_reg != IDLE);
  assign cctrans     = (state_reg == LOOKUP) || sending || (state_reg == UPDATE);
  assign ccwrite     = sending;
  assign snp_wen     = (state_reg == UPDATE);
  assign snp_way     = (state_reg == UPDATE) && way_reg;
  assign snp_valid_n = (state_reg == UPDATE) && !inv_reg;
  assign snp_dirty_n = 1'b0;
  assign snp_idx     = addr_reg[IDX_W-1:0];
  assign dstore      = sending ? blk_words[{way_reg, word_sel}] : '0;
  assign daddr       = sending ? {addr_reg, word_sel, 2'b00} : '0;

`ifdef LLSC_SNOOP_EN
  logic link_clear_reg;
  logic entering_end;

  // Fires once on the first UPDATE/DONE cycle, not again on UPDATE -> DONE.
  assign entering_end = ((state_next == UPDATE) || (state_next == DONE)) &&
                        !((state_reg == UPDATE) || (state_reg == DONE));

  always_ff @(posedge CLK) begin
    if (nRST) begin
      link_clear_reg <= 1'b0;
    end else begin
      link_clear_reg <= entering_end && inv_reg && (addr_reg == link_addr[31:3]);
    end
  end

  assign link_clear = link_clear_reg;

  logic unused_sink;
  assign unused_sink = &{1'b0, ccsnoopaddr[2:0], link_addr[2:0], SETS[0]};
`else
  assign link_clear = 1'b0;

  logic unused_sink;
  assign unused_sink = &{1'b0, ccsnoopaddr[2:0], link_addr, SETS[0]};
`endif

endmodule

// File: doc/snoop_responder.md
Name: snoop_responder

Overview:
Cache-side responder to the coherence bus controller's snoop requests, instantiated once per dcache. It receives ccwait, ccsnoopaddr and ccinv, and looks up the 2-way dcache tag array. A Modified block is written back as two words over dstore, then the line is downgraded to Shared or invalidated. The bus controller is notified through cctrans and ccwrite. snoop_busy stalls the owning dcache controller.

Parameters:
SETS, 8, number of dcache sets (power of two)
IDX_W, 3, log2(SETS); tag width TAG_W = 29 - IDX_W (26 at default)

Ports:
CLK  input  1  system clock, rising edge
nRST  input  1  reset, synchronous active-high (1 = reset)
ccwait  input  1  bus controller is holding this cache for a snoop
ccinv  input  1  snoop requests invalidation (write-miss or upgrade by the other core)
ccsnoopaddr  input  32  snooped word address
dwait  input  1  write-back word handshake; 0 = current dstore word accepted this cycle
cctrans  output  1  responder active / transition in progress
ccwrite  output  1  this cache supplies the block (hit in M)
dstore  output  32  write-back data word
daddr  output  32  write-back word address
snp_idx  output  IDX_W  tag-array read index (from latched address)
way_valid  input  2  valid bit per way at snp_idx
way_dirty  input  2  dirty bit per way (dirty = M)
way_tag  input  2*TAG_W  tag per way
way_data  input  2*2*32  block data per way, word0 in low bits
snp_wen  output  1  one-cycle tag-array state write
snp_way  output  1  way written
snp_valid_n  output  1  new valid bit
snp_dirty_n  output  1  new dirty bit
snoop_busy  output  1  dcache controller must stall its own access
link_clear  output  1  clear LL/SC link register (see Optional Feature)
link_addr  input  32  current link register address

Behaviour:
- Address split: tag = [31:3+IDX_W], idx = [2+IDX_W:3], blkoff = [2], byte = [1:0].
- Reset (nRST = 1 at a rising edge): state goes to IDLE. All outputs are 0, including dstore and daddr. Latched address and inv flag are cleared. No tag write occurs. Reset mid-transfer aborts without any tag update.
- IDLE: outputs 0. If ccwait = 1, latch ccsnoopaddr and ccinv, then go to LOOKUP.
- LOOKUP (1 cycle): snoop_busy = 1 and cctrans = 1. Hit when way_valid[w] and way_tag[w] equals the latched tag; way0 has priority on a double match.
  - Hit and dirty: go to SEND0 and assert ccwrite.
  - Hit and clean: go to UPDATE.
  - Miss: go to DONE.
  - Latch hit way.
- SEND0: cctrans = 1 and ccwrite = 1. dstore = word0 of the hit way; daddr = {tag, idx, 3'b000}. Hold until dwait = 0, then go to SEND1.
- SEND1: same, with word1 and daddr = {tag, idx, 3'b100}. When dwait = 0, go to UPDATE.
- UPDATE (1 cycle): snp_wen = 1 and snp_way = hit way. Go to DONE.
  - inv = 1: valid_n = 0, dirty_n = 0 (→ I).
  - inv = 0: valid_n = 1, dirty_n = 0 (M → S; S stays S).
- DONE: cctrans = 0, ccwrite = 0, snoop_busy = 1. Go to IDLE when ccwait = 0.
- Aborts:
  - ccwait falls in LOOKUP, SEND0 or SEND1: go straight to IDLE with no tag write; the line keeps its state.
  - ccwait falls in UPDATE: the update still completes.
- Latency: clean hit gives cctrans for 2 cycles and snp_wen 2 cycles after ccwait. Dirty hit with dwait = 0 throughout gives UPDATE 4 cycles after ccwait.
- snoop_busy is 1 in every state except IDLE. A simultaneous own-core request and ccwait is resolved by the snoop winning.
- Outputs are registered from state except snp_idx, dstore and daddr, which come combinationally from latched registers and way_data.

Optional Feature:
LLSC_SNOOP_EN.
- Defined: when UPDATE or DONE is entered with inv = 1 and latched address [31:3] equals link_addr[31:3], link_clear pulses 1 for one cycle. This holds on a cache miss as well.
- Undefined: link_clear is tied to 0.

Decomposition:
- cpu_types_pkg:
  - snoop_state_t enum {IDLE, LOOKUP, SEND0, SEND1, UPDATE, DONE}
  - dcache_snp_addr_t packed struct {tag, idx, blkoff, bytoff}
  - WAYS = 2, BLK_WORDS = 2
- One sub-module, snoop_tag_match (combinational): inputs are tags, valid and latched tag; outputs are hit and hit_way.

Test Plan:
- Reset held while in SEND0 with ccwait = 1 → next cycle IDLE, all outputs 0, snp_wen never asserted.
- Dirty hit way1 at 0x0000_0048, ccinv = 0, dwait = 0 → dstore = word0, then word1. daddr = 0x48, then 0x4C. UPDATE writes way1 valid = 1, dirty = 0. cctrans falls after.
- Clean hit way0, ccinv = 1 → ccwrite never 1; snp_wen with valid_n = 0, dirty_n = 0, 2 cycles after ccwait.
- Miss (valid = 2'b00) → cctrans high 1 cycle, no snp_wen; DONE holds until ccwait = 0, then IDLE.
- Dirty hit with dwait = 1 for 3 cycles in SEND0, then ccwait drops → IDLE, no snp_wen, snoop_busy = 0 next cycle.
- LLSC_SNOOP_EN, link_addr = 0x100, ccinv = 1, ccsnoopaddr = 0x104, miss → link_clear pulses exactly one cycle.
